lea128_round_key_gen: RTL and testbench

- Iterative LEA-128 key schedule generator, directly upstream of the round XOR stage.
- Consumes its 192-bit RoundKey bus, one round key per round.
- On Start, loads the 128-bit master key and emits NUM_ROUNDS round keys in order RK_0..RK_{NUM_ROUNDS-1} over a valid/ready handshake.
- Holds four 32-bit T-words; computes one round of the schedule per accepted key, so a stalled consumer costs no extra latency.

---
 rtl/lea128_round_key_gen.sv | 89 ++++++++
 tb/tb_lea128_round_key_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lea128_round_key_gen.sv
// lea128_round_key_gen: iterative LEA-128 key schedule, one 192-bit round key per accepted handshake.
module lea128_round_key_gen #(
    parameter int NUM_ROUNDS = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Start,
    input  logic [127:0] Key,
    output logic [191:0] RoundKey,
    output logic         RkValid,
    input  logic         RkReady,
    output logic [4:0]   RoundIdx,
    output logic         Busy,
    output logic         Done
);
    typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;
    localparam logic [127:0] DELTAS = 128'h78df30ec_79e27c8a_44626b02_c3efe9db;
    state_t            state_q;
    logic [3:0][31:0]  t_q, t_d;
    logic [191:0]      rk_q, rk_d;
    logic [4:0]        idx_q, r;
    logic [31:0]       d;
    logic              valid_q, busy_q, done_q;

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] y;
        y = {x, x} << n;
        return y[63:32];
    endfunction

    // LOAD computes round idx_q; a handshake in OUT computes the following round
    assign r = (state_q == OUT) ? idx_q + 5'd1 : idx_q;
    assign d = DELTAS[{r[1:0], 5'b0} +: 32];

    always_comb begin
        t_d[0] = rol(t_q[0] + rol(d, r), 5'd1);
        t_d[1] = rol(t_q[1] + rol(d, r + 5'd1), 5'd3);
        t_d[2] = rol(t_q[2] + rol(d, r + 5'd2), 5'd6);
        t_d[3] = rol(t_q[3] + rol(d, r + 5'd3), 5'd11);
        rk_d   = {t_d[1], t_d[3], t_d[1], t_d[2], t_d[1], t_d[0]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            t_q     <= '0;
            rk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (Start) begin
                    t_q     <= Key;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
                    t_q     <= t_d;
                    rk_q    <= rk_d;
                    valid_q <= 1'b1;
                    state_q <= OUT;
                end
                OUT: if (RkReady) begin
                    if (idx_q == 5'(NUM_ROUNDS - 1)) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                        rk_q  <= rk_d;
                        t_q   <= t_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RoundKey = rk_q;
    assign RkValid  = valid_q;
    assign RoundIdx = idx_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
endmodule

// File: tb/tb_lea128_round_key_gen.sv
// tb_lea128_round_key_gen: directed checks of the LEA-128 key schedule against a reference model.
module tb_lea128_round_key_gen;
    logic         CLK = 1'b0, RST = 1'b1, Start = 1'b0, RkReady = 1'b0;
    logic [127:0] Key = '0;
    logic [191:0] RoundKey;
    logic         RkValid, Busy, Done;
    logic [4:0]   RoundIdx;
    logic         s1_start = 1'b0, s1_ready = 1'b0;
    logic [191:0] s1_rk;
    logic         s1_valid, s1_busy, s1_done;
    logic [4:0]   s1_idx;

    int n_chk = 0, n_err = 0;
    logic [191:0] golden [24];
    localparam logic [191:0] RK0_K0 = 192'h3efe9dbc_fa76f0fb_3efe9dbc_efe9dbc3_3efe9dbc_87dfd3b7;
    localparam logic [127:0] KEY_A  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] KEY_B  = 128'h01234567_89abcdef_fedcba98_76543210;

    lea128_round_key_gen dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Key(Key), .RoundKey(RoundKey),
        .RkValid(RkValid), .RkReady(RkReady), .RoundIdx(RoundIdx), .Busy(Busy), .Done(Done)
    );
    lea128_round_key_gen #(.NUM_ROUNDS(1)) dut1 (
        .CLK(CLK), .RST(RST), .Start(s1_start), .Key(128'h0), .RoundKey(s1_rk),
        .RkValid(s1_valid), .RkReady(s1_ready), .RoundIdx(s1_idx), .Busy(s1_busy), .Done(s1_done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic gen(input logic [127:0] key);
        logic [31:0] t [4];
        logic [31:0] dl [4];
        int sh [4];
        dl = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
        sh = '{1, 3, 6, 11};
        for (int j = 0; j < 4; j++) t[j] = key[32*j +: 32];
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 4; j++) t[j] = rl(t[j] + rl(dl[i % 4], (i + j) % 32), sh[j]);
            golden[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
        end
    endtask

    task automatic run(input logic [127:0] key, input bit bp, input bit hold, input logic [127:0] key2);
        int n = 0, cyc = 0;
        gen(key);
        Key = key; Start = 1'b1; RkReady = 1'b0;
        @(negedge CLK);
        Start = hold;
        if (hold) Key = key2;
        check("lat1_valid", RkValid, 0);
        check("lat1_busy", Busy, 1);
        @(negedge CLK);
        check("lat2_valid", RkValid, 1);
        if (key == 0) check("rk0_key0", RoundKey, RK0_K0);
        while (n < 24 && cyc < 400) begin
            check("valid", RkValid, 1);
            check("idx", RoundIdx, n);
            check("rk", RoundKey, golden[n]);
            RkReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (RkReady) n++;
            cyc++;
            @(negedge CLK);
        end
        check("count", n, 24);
        check("done", Done, 1);
        check("busy_end", Busy, 0);
        check("valid_end", RkValid, 0);
        check("idx_hold", RoundIdx, 23);
        check("rk_hold", RoundKey, golden[23]);
        @(negedge CLK);
        check("done_pulse", Done, 0);
        if (hold) begin
            check("restart_busy", Busy, 1);
            gen(key2);
            Start = 1'b0;
            @(negedge CLK);
            check("restart_valid", RkValid, 1);
            check("restart_rk0", RoundKey, golden[0]);
        end else begin
            check("idle_busy", Busy, 0);
        end
    endtask

    initial begin
        int c;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_rk", RoundKey, 0);
        check("rst_valid", RkValid, 0);
        check("rst_idx", RoundIdx, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        RST = 1'b0;
        @(negedge CLK);
        // single-round instance
        s1_start = 1'b1;
        @(negedge CLK);
        s1_start = 1'b0;
        @(negedge CLK);
        check("n1_valid", s1_valid, 1);
        check("n1_idx", s1_idx, 0);
        check("n1_rk", s1_rk, RK0_K0);
        s1_ready = 1'b1;
        @(negedge CLK);
        s1_ready = 1'b0;
        check("n1_done", s1_done, 1);
        check("n1_valid_end", s1_valid, 0);
        check("n1_busy_end", s1_busy, 0);
        @(negedge CLK);
        check("n1_done_pulse", s1_done, 0);
        run(128'h0, 1'b0, 1'b0, 128'h0);
        run(KEY_A, 1'b1, 1'b0, 128'h0);
        run(KEY_A, 1'b0, 1'b1, KEY_B);
        // advance KEY_B schedule to round 10, stall there, then reset asynchronously
        RkReady = 1'b1;
        c = 0;
        while (RoundIdx != 5'd10 && c < 40) begin
            @(negedge CLK);
            c++;
        end
        RkReady = 1'b0;
        check("stall_idx", RoundIdx, 10);
        check("stall_rk", RoundKey, golden[10]);
        @(negedge CLK);
        check("stall_hold_rk", RoundKey, golden[10]);
        check("stall_hold_idx", RoundIdx, 10);
        #2 RST = 1'b1;
        #1;
        check("arst_rk", RoundKey, 0);
        check("arst_valid", RkValid, 0);
        check("arst_idx", RoundIdx, 0);
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        @(negedge CLK);
        check("arst_no_done", Done, 0);
        RST = 1'b0;
        Key = 128'h0;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        check("post_rst_valid", RkValid, 1);
        check("post_rst_idx", RoundIdx, 0);
        check("post_rst_rk", RoundKey, RK0_K0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
